// File: rtl/sum_tree_pkg.sv
// Shared constants, beat metadata type and elaboration helpers for the sum-tree accumulator.
// Pure compile-time content: no latency, no flow control.
package sum_tree_pkg;

  localparam int DEF_N_IN  = 121;
  localparam int DEF_IN_W  = 20;
  localparam int DEF_ACC_W = 27;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } meta_t;

  localparam int META_W = $bits(meta_t);

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  // Operand count entering tree level lvl when the tree starts with n operands.
  function automatic int lvl_count(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
    return c;
  endfunction

endpackage

// File: rtl/sum_tree_level.sv
// One registered pairwise-add level: COUNT operands in, ceil(COUNT/2) operands one bit wider out.
// Latency 1 cycle; no backpressure, beat metadata is registered alongside the data.
module sum_tree_level
  import sum_tree_pkg::*;
#(
  parameter int COUNT = 2,
  parameter int WIDTH = 8,
  localparam int OCNT = (COUNT + 1) / 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [COUNT*WIDTH-1:0]    in_data,
  input  logic [META_W-1:0]         in_meta,
  output logic [OCNT*(WIDTH+1)-1:0] out_data,
  output logic [META_W-1:0]         out_meta
);

  logic [OCNT*(WIDTH+1)-1:0] sum_nxt;

  for (genvar j = 0; j < OCNT; j++) begin : g_pair
    if (2 * j + 1 < COUNT) begin : g_add
      assign sum_nxt[j*(WIDTH+1) +: WIDTH+1] = {1'b0, in_data[2*j*WIDTH +: WIDTH]}
                                             + {1'b0, in_data[(2*j+1)*WIDTH +: WIDTH]};
    end else begin : g_pass
      // Odd leftover operand is forwarded unchanged, zero-extended.
      assign sum_nxt[j*(WIDTH+1) +: WIDTH+1] = {1'b0, in_data[2*j*WIDTH +: WIDTH]};
    end
  end

  // Data is only qualified by out_meta, so it needs no reset.
  always_ff @(posedge clk) begin
    out_data <= sum_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_meta <= '0;
    else     out_meta <= in_meta;
  end

endmodule

// File: rtl/sum_tree_acc.sv
// Registered adder tree feeding a framed accumulator with optional saturation and sticky overflow.
// Latency clog2(N_IN)+1 cycles from last beat to out_valid; no backpressure, one beat per cycle.
module sum_tree_acc
  import sum_tree_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter bit SAT   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*IN_W-1:0]   in_data,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic                   in_last,
  output logic [ACC_W-1:0]       out_sum,
  output logic                   out_valid,
  output logic                   out_ovf
);

  localparam int LVLS = clog2(N_IN);
  localparam int TW   = IN_W + LVLS;

  meta_t         in_meta;
  meta_t         tree_meta;
  logic [TW-1:0] tree_sum;

  assign in_meta = '{vld: in_valid, first: in_first, last: in_last};

  if (LVLS == 0) begin : g_notree
    assign tree_sum  = in_data;
    assign tree_meta = in_meta;
  end else begin : g_tree
    for (genvar i = 0; i < LVLS; i++) begin : g_lvl
      localparam int CNT  = lvl_count(N_IN, i);
      localparam int OCNT = lvl_count(N_IN, i + 1);

      logic [CNT*(IN_W+i)-1:0]    lvl_in;
      logic [OCNT*(IN_W+i+1)-1:0] lvl_out;
      logic [META_W-1:0]          meta_in;
      logic [META_W-1:0]          meta_out;

      if (i == 0) begin : g_src
        assign lvl_in  = in_data;
        assign meta_in = in_meta;
      end else begin : g_chain
        assign lvl_in  = g_lvl[i-1].lvl_out;
        assign meta_in = g_lvl[i-1].meta_out;
      end

      sum_tree_level #(
        .COUNT (CNT),
        .WIDTH (IN_W + i)
      ) u_level (
        .clk      (clk),
        .rst      (rst),
        .in_data  (lvl_in),
        .in_meta  (meta_in),
        .out_data (lvl_out),
        .out_meta (meta_out)
      );
    end

    assign tree_sum  = g_lvl[LVLS-1].lvl_out;
    assign tree_meta = g_lvl[LVLS-1].meta_out;
  end

  logic [ACC_W-1:0] acc;
  logic             ovf_sticky;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf_nxt;

  // A first beat restarts both the running sum and the overflow history.
  always_comb begin
    acc_base = tree_meta.first ? '0 : acc;
    sum_ext  = {{(ACC_W + 1 - TW){1'b0}}, tree_sum} + {1'b0, acc_base};
    ovf_nxt  = sum_ext[ACC_W] | (~tree_meta.first & ovf_sticky);
    acc_nxt  = (SAT && sum_ext[ACC_W]) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
      out_sum    <= '0;
      out_valid  <= 1'b0;
      out_ovf    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (tree_meta.vld) begin
        if (tree_meta.last) begin
          out_sum    <= acc_nxt;
          out_ovf    <= ovf_nxt;
          out_valid  <= 1'b1;
          acc        <= '0;
          ovf_sticky <= 1'b0;
        end else begin
          acc        <= acc_nxt;
          ovf_sticky <= ovf_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_sum_tree_acc.sv
// Directed and random checks of sum_tree_acc against a frame-level arithmetic model,
// run on a saturating and a wrapping instance driven with identical stimulus.
module tb_sum_tree_acc;

  localparam int     N_IN  = 121;
  localparam int     IN_W  = 20;
  localparam int     ACC_W = 27;
  localparam int     L     = 8;
  localparam longint MAXV  = (longint'(1) << ACC_W) - 1;
  localparam longint OPMAX = (longint'(1) << IN_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_IN*IN_W-1:0] in_data;
  logic                 in_valid, in_first, in_last;
  logic [ACC_W-1:0]     sum_s, sum_w;
  logic                 vld_s, vld_w, ovf_s, ovf_w;

  always #5 clk = ~clk;

  sum_tree_acc #(.N_IN(N_IN), .IN_W(IN_W), .ACC_W(ACC_W), .SAT(1'b1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last),
    .out_sum(sum_s), .out_valid(vld_s), .out_ovf(ovf_s)
  );

  sum_tree_acc #(.N_IN(N_IN), .IN_W(IN_W), .ACC_W(ACC_W), .SAT(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last),
    .out_sum(sum_w), .out_valid(vld_w), .out_ovf(ovf_w)
  );

  typedef struct {
    longint sum_s;
    bit     ovf_s;
    longint sum_w;
    bit     ovf_w;
    int     cyc;
  } res_t;

  res_t   exp_q[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc    = 0;
  longint acc_s, acc_w;
  bit     ov_s, ov_w;
  longint hold_s, hold_w;
  bit     hold_ovs, hold_ovw;
  longint seen_s[$];
  longint seen_w[$];
  bit     seen_ovs[$];
  bit     seen_ovw[$];
  int     seen_cyc[$];
  logic [IN_W-1:0] ops [N_IN];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_seen();
    seen_s.delete(); seen_w.delete(); seen_ovs.delete(); seen_ovw.delete(); seen_cyc.delete();
  endtask

  task automatic model_reset();
    exp_q.delete();
    acc_s = 0; acc_w = 0; ov_s = 0; ov_w = 0;
    hold_s = 0; hold_w = 0; hold_ovs = 0; hold_ovw = 0;
  endtask

  task automatic check_outputs();
    bit due;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
    due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    if (due) begin
      hold_s   = exp_q[0].sum_s;
      hold_ovs = exp_q[0].ovf_s;
      hold_w   = exp_q[0].sum_w;
      hold_ovw = exp_q[0].ovf_w;
      void'(exp_q.pop_front());
    end
    if (vld_s === 1'b1) begin
      seen_s.push_back(longint'(sum_s));
      seen_w.push_back(longint'(sum_w));
      seen_ovs.push_back(ovf_s);
      seen_ovw.push_back(ovf_w);
      seen_cyc.push_back(cyc);
    end
    chk("valid_sat",  vld_s, due);
    chk("valid_wrap", vld_w, due);
    chk("sum_sat",    sum_s, hold_s);
    chk("sum_wrap",   sum_w, hold_w);
    chk("ovf_sat",    ovf_s, hold_ovs);
    chk("ovf_wrap",   ovf_w, hold_ovw);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  // Frame-level model: plain integer sums, clamp or modulo on overflow.
  task automatic model_beat(input bit f, input bit l);
    longint s = 0;
    for (int k = 0; k < N_IN; k++) s += ops[k];
    if (f) begin
      acc_s = 0; acc_w = 0; ov_s = 0; ov_w = 0;
    end
    acc_s += s;
    if (acc_s > MAXV) begin acc_s = MAXV; ov_s = 1; end
    acc_w += s;
    if (acc_w > MAXV) begin acc_w -= MAXV + 1; ov_w = 1; end
    if (l) begin
      exp_q.push_back('{acc_s, ov_s, acc_w, ov_w, cyc + L});
      acc_s = 0; acc_w = 0; ov_s = 0; ov_w = 0;
    end
  endtask

  // val >= 0: every operand equals val; -1: random full range; -2: random small.
  task automatic beat(input longint val, input bit v, input bit f, input bit l);
    for (int k = 0; k < N_IN; k++) begin
      if (val >= 0)       ops[k] = IN_W'(val);
      else if (val == -1) ops[k] = IN_W'($urandom);
      else                ops[k] = IN_W'($urandom_range(0, 1023));
      in_data[k*IN_W +: IN_W] = ops[k];
    end
    in_valid = v;
    in_first = f;
    in_last  = l;
    if (v) model_beat(f, l);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(-1, 1'b0, 1'($urandom), 1'($urandom));
  endtask

  initial begin
    int c0;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    model_reset();
    #1 check_outputs();
    repeat (2) step();
    rst = 1'b0;
    step();

    clear_seen(); c0 = cyc;
    beat(1, 1, 1, 1);
    idle(L + 1);
    chk("r030_count", seen_s.size(), 1);
    chk("r030_sum",   seen_s[0], 121);
    chk("r030_ovf",   seen_ovs[0], 0);
    chk("r030_lat",   seen_cyc[0] - c0, L);

    clear_seen();
    beat(OPMAX, 1, 1, 1);
    idle(L + 1);
    chk("r031_sum_sat",  seen_s[0], 126877575);
    chk("r031_sum_wrap", seen_w[0], 126877575);
    chk("r031_ovf",      seen_ovs[0], 0);

    clear_seen();
    beat(OPMAX, 1, 1, 0);
    beat(OPMAX, 1, 0, 1);
    idle(L + 1);
    chk("r032_sum_sat",  seen_s[0], 134217727);
    chk("r032_ovf_sat",  seen_ovs[0], 1);
    chk("r032_sum_wrap", seen_w[0], 119537422);
    chk("r032_ovf_wrap", seen_ovw[0], 1);

    clear_seen();
    beat(1, 1, 1, 0);
    idle(1);
    beat(2, 1, 0, 0);
    idle(1);
    beat(3, 1, 0, 1);
    idle(L + 1);
    chk("r033_pulses", seen_s.size(), 1);
    chk("r033_sum",    seen_s[0], 726);

    clear_seen();
    beat(1, 1, 1, 1);
    beat(2, 1, 1, 1);
    idle(L + 1);
    chk("r034_pulses", seen_s.size(), 2);
    chk("r034_first",  seen_s[0], 121);
    chk("r034_second", seen_s[1], 242);
    chk("r034_gap",    seen_cyc[1] - seen_cyc[0], 1);

    beat(1, 1, 1, 0);
    beat(3, 1, 0, 1);
    idle(1);
    rst = 1'b1;
    model_reset();
    clear_seen();
    #1 check_outputs();
    step();
    rst = 1'b0;
    beat(1, 1, 1, 1);
    idle(L + 1);
    chk("r035_pulses", seen_s.size(), 1);
    chk("r035_sum",    seen_s[0], 121);

    for (int i = 0; i < 80; i++) begin
      int mode;
      mode = $urandom_range(0, 2);
      beat((mode == 0) ? -1 : (mode == 1) ? -2 : OPMAX,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end
    idle(L + 2);
    chk("drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sum_tree_acc.md
SUM_TREE_ACC -- requirements
Module: sum_tree_acc

Interface
REQ-001 Parameter N_IN, default 121: number of input operands per beat.
REQ-002 Parameter IN_W, default 20: unsigned width of each operand.
REQ-003 Parameter ACC_W, default 27: accumulator and result width; must satisfy ACC_W >= IN_W + clog2(N_IN).
REQ-004 Parameter SAT, default 1: 1 clamps the result on overflow, 0 wraps it modulo 2^ACC_W.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-high.
REQ-007 Port in_data, input, N_IN*IN_W: packed operands; operand k occupies bits [k*IN_W +: IN_W].
REQ-008 Port in_valid, input, 1: beat qualifier for in_data, in_first and in_last.
REQ-009 Port in_first, input, 1: the beat starts a new accumulation.
REQ-010 Port in_last, input, 1: the beat ends the accumulation and produces a result.
REQ-011 Port out_sum, output, ACC_W: accumulated result.
REQ-012 Port out_valid, output, 1: one-cycle pulse marking a new out_sum.
REQ-013 Port out_ovf, output, 1: the result accompanying out_valid overflowed ACC_W.

Function
REQ-014 Tree: pairwise unsigned add, ceil(log2 N_IN) levels, each level registered; each level widens by 1 bit; an odd leftover operand passes to the next level zero-extended.
REQ-015 Pipeline: valid/first/last are carried alongside each level; no backpressure; one beat per cycle accepted.
REQ-016 Latency: out_valid rises exactly L = ceil(log2 N_IN) + 1 cycles after an accepted in_last beat (L = 8 at defaults).
REQ-017 Accumulator, per tree-output beat with valid=1: if first, acc = tree; else acc = acc + tree (ACC_W+1-bit add).
REQ-018 On a beat with last=1, the final value is registered to out_sum, out_valid pulses 1 cycle, and acc clears to 0.
REQ-019 first and last on the same beat: result = that beat's tree sum only.
REQ-020 Beat without first following a last: accumulation starts from 0.
REQ-021 Beats with in_valid=0 are bubbles: no acc change, no result.
REQ-022 Overflow: set when any add in the current accumulation exceeds 2^ACC_W-1; flag is sticky until the result is emitted.
REQ-023 Overflow with SAT=1: acc and out_sum clamp to 2^ACC_W-1 and stay there until last.
REQ-024 Overflow with SAT=0: values wrap modulo 2^ACC_W.
REQ-025 out_sum and out_ovf hold their values between out_valid pulses.

Reset
REQ-026 rst asserted: all pipeline valid flags, acc, the sticky overflow flag, out_sum, out_valid and out_ovf go to 0 immediately.
REQ-027 Reset mid-accumulation or mid-pipeline discards all in-flight beats; no result emits for them.

Structure
REQ-028 Package sum_tree_pkg holds the clog2 constant function and the default N_IN/IN_W/ACC_W constants.
REQ-029 Sub-module sum_tree_level implements one registered pairwise-add level (parameters: count, width) and is instantiated once per level by a generate loop.

Verification
REQ-030 Defaults, all operands 1, single beat with first=last=1 -> out_sum=121, out_valid at cycle 8, out_ovf=0.
REQ-031 All operands 2^20-1, one beat -> out_sum=126,877,575, out_ovf=0.
REQ-032 Two max beats (first then last), SAT=1 -> out_sum=134,217,727, out_ovf=1; SAT=0 -> out_sum=119,537,422, out_ovf=1.
REQ-033 Beats of operand 1/2/3 (first, mid, last) with one bubble cycle between them -> out_sum=726, a single out_valid pulse.
REQ-034 Back-to-back single-beat results of 121 and 242 on consecutive cycles -> two consecutive out_valid pulses, correct order, no cross-accumulation.
REQ-035 rst pulse 3 cycles after a first beat, then a first=last beat of all 1 -> out_sum=121 only; no stale result.
